// File: rtl/fir_pkg.sv
// Shared FIR coefficient-path definitions: loader state encoding, the default
// filter geometry used by the filter and the loader, and the XOR checksum
// helper used when FIR_COEFF_CHECKSUM_EN is defined.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int FIR_NUM_TAPS = 3;
  localparam int FIR_COEFF_W  = 3;

  // Upper bounds for the checksum helper's generic argument/result widths.
  // Callers zero-extend their packed set and keep the low coeff_w bits.
  localparam int CSUM_MAX_VEC_W = 256;
  localparam int CSUM_MAX_W     = 32;

  // XOR of num_taps coefficients of coeff_w bits, packed LSB-first in vec.
  function automatic logic [CSUM_MAX_W-1:0] xor_checksum(
    input logic [CSUM_MAX_VEC_W-1:0] vec,
    input int                        num_taps,
    input int                        coeff_w
  );
    logic [CSUM_MAX_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < num_taps; k++) begin
      for (int b = 0; b < coeff_w; b++) begin
        acc[b] = acc[b] ^ vec[k*coeff_w + b];
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register pair. The shadow bank takes indexed
// writes while a frame streams in; swap copies the whole shadow set into the
// active bank in one edge, so the taps never see a partial set.
// FIR_COEFF_CHECKSUM_EN adds a packed view of the shadow bank for checking.
module fir_coeff_bank #(
  parameter int NUM_TAPS = fir_pkg::FIR_NUM_TAPS,
  parameter int COEFF_W  = fir_pkg::FIR_COEFF_W,
  parameter int IDX_W    = $clog2(NUM_TAPS + 1)
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [COEFF_W-1:0]          wr_data,
  input  logic                        swap,
  output logic [NUM_TAPS*COEFF_W-1:0] coeffs
`ifdef FIR_COEFF_CHECKSUM_EN
  ,
  output logic [NUM_TAPS*COEFF_W-1:0] shadow_flat
`endif
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      logic [COEFF_W-1:0] shadow_reg;
      logic [COEFF_W-1:0] active_reg;

      // Per-tap shadow write and atomic shadow-to-active copy on swap.
      always_ff @(posedge clk) begin
        if (srst) begin
          shadow_reg <= '0;
          active_reg <= '0;
        end else begin
          if (wr_en && (wr_idx == IDX_W'(gi))) begin
            shadow_reg <= wr_data;
          end
          if (swap) begin
            active_reg <= shadow_reg;
          end
        end
      end

      assign coeffs[gi*COEFF_W +: COEFF_W] = active_reg;
`ifdef FIR_COEFF_CHECKSUM_EN
      assign shadow_flat[gi*COEFF_W +: COEFF_W] = shadow_reg;
`endif
    end
  endgenerate

endmodule

// File: rtl/fir_coeff_loader.sv
// Coefficient loader: accepts a frame of coefficient beats over valid/ready,
// stages them in the shadow bank and commits them atomically to the active
// bank once the filter releases i_hold.
// FIR_COEFF_CHECKSUM_EN: frames carry one extra trailing XOR checksum beat;
// a mismatching frame is dropped with an error pulse and no commit.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int COEFF_W  = FIR_COEFF_W,
  parameter int IDX_W    = $clog2(NUM_TAPS + 1)
) (
  input  logic                        i_CLK,
  input  logic                        i_RST,
  input  logic                        i_valid,
  input  logic                        i_start,
  input  logic [COEFF_W-1:0]          i_data,
  output logic                        o_ready,
  input  logic                        i_hold,
  output logic [NUM_TAPS*COEFF_W-1:0] o_coeffs,
  output logic                        o_commit,
  output logic                        o_busy,
  output logic                        o_err
);

`ifdef FIR_COEFF_CHECKSUM_EN
  localparam int FRAME_LEN = NUM_TAPS + 1;
`else
  localparam int FRAME_LEN = NUM_TAPS;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               commit_reg;
  logic               err_reg;
  logic               busy_reg;

  logic               accept;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic               swap;

  assign o_ready  = (state_reg != COMMIT);
  assign accept   = i_valid && o_ready;
  assign swap     = (state_reg == COMMIT) && !i_hold;
  assign o_commit = commit_reg;
  assign o_err    = err_reg;
  assign o_busy   = busy_reg;

`ifdef FIR_COEFF_CHECKSUM_EN
  logic [NUM_TAPS*COEFF_W-1:0] shadow_flat;
  logic [CSUM_MAX_W-1:0]       csum_full;
  logic                        csum_ok;

  assign csum_full = xor_checksum(CSUM_MAX_VEC_W'(shadow_flat), NUM_TAPS, COEFF_W);
  assign csum_ok   = (csum_full[COEFF_W-1:0] == i_data);
`endif

  // Shadow write steering: a start beat always lands in slot 0, continuation
  // beats land at the running index (the checksum beat is never stored).
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    if (accept) begin
      if (i_start) begin
        wr_en  = 1'b1;
        wr_idx = '0;
      end else if ((state_reg == LOAD) && (idx_reg < IDX_W'(NUM_TAPS))) begin
        wr_en  = 1'b1;
        wr_idx = idx_reg;
      end
    end
  end

  // Frame FSM with registered commit/error pulses and busy flag.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      commit_reg <= 1'b0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      commit_reg <= 1'b0;
      err_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (i_start) begin
              idx_reg   <= IDX_W'(1);
              state_reg <= LOAD;
              busy_reg  <= 1'b1;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (i_start) begin
              err_reg <= 1'b1;
              idx_reg <= IDX_W'(1);
            end else if (idx_reg == LAST_IDX) begin
              idx_reg <= '0;
`ifdef FIR_COEFF_CHECKSUM_EN
              if (csum_ok) begin
                state_reg <= COMMIT;
              end else begin
                err_reg   <= 1'b1;
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
`else
              state_reg <= COMMIT;
`endif
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        COMMIT: begin
          if (!i_hold) begin
            commit_reg <= 1'b1;
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  fir_coeff_bank #(
    .NUM_TAPS (NUM_TAPS),
    .COEFF_W  (COEFF_W),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk     (i_CLK),
    .srst    (i_RST),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (i_data),
    .swap    (swap),
    .coeffs  (o_coeffs)
`ifdef FIR_COEFF_CHECKSUM_EN
    ,
    .shadow_flat (shadow_flat)
`endif
  );

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader (3 taps x 3 bits). Inputs are driven
// 1 time unit after each rising edge and outputs are sampled at that point.
// With FIR_COEFF_CHECKSUM_EN defined, frames carry a trailing checksum beat.
module tb_fir_coeff_loader;

  logic       clk;
  logic       rst;
  logic       valid;
  logic       start;
  logic [2:0] data;
  logic       ready;
  logic       hold;
  logic [8:0] coeffs;
  logic       commit;
  logic       busy;
  logic       err;

  int compared;
  int mismatched;

  fir_coeff_loader #(
    .NUM_TAPS (3),
    .COEFF_W  (3)
  ) dut (
    .i_CLK    (clk),
    .i_RST    (rst),
    .i_valid  (valid),
    .i_start  (start),
    .i_data   (data),
    .o_ready  (ready),
    .i_hold   (hold),
    .o_coeffs (coeffs),
    .o_commit (commit),
    .o_busy   (busy),
    .o_err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat presented for one cycle; returns in the cycle after the accept.
  task automatic beat(input logic s, input logic [2:0] d);
    valid = 1'b1;
    start = s;
    data  = d;
    tick();
    valid = 1'b0;
    start = 1'b0;
    data  = 3'd0;
  endtask

  // Full frame c0,c1,c2 (start on c0) plus checksum beat when enabled.
  task automatic send_frame(input logic [2:0] c0, input logic [2:0] c1,
                            input logic [2:0] c2, input logic [2:0] csum);
    beat(1'b1, c0);
    beat(1'b0, c1);
    beat(1'b0, c2);
`ifdef FIR_COEFF_CHECKSUM_EN
    beat(1'b0, csum);
`else
    if (csum === 3'bxxx) $display("unused checksum beat");
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    compared++;
    if (coeffs !== 9'h000) begin mismatched++; $display("FAIL reset_coeffs: got %h want %h", coeffs, 9'h000); end
    compared++;
    if (commit !== 1'b0) begin mismatched++; $display("FAIL reset_commit: got %b want 0", commit); end
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++;
    if (ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", ready); end
    $display("reset done");
  endtask

  task automatic test_basic();
    beat(1'b1, 3'd4);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy_first: got %b want 1", busy); end
    beat(1'b0, 3'd1);
    beat(1'b0, 3'd2);
`ifdef FIR_COEFF_CHECKSUM_EN
    beat(1'b0, 3'd7);
`endif
    // cycle N+1
    compared++;
    if (ready !== 1'b0) begin mismatched++; $display("FAIL basic_ready_n1: got %b want 0", ready); end
    compared++;
    if (commit !== 1'b0) begin mismatched++; $display("FAIL basic_commit_n1: got %b want 0", commit); end
    compared++;
    if (coeffs !== 9'h000) begin mismatched++; $display("FAIL basic_coeffs_n1: got %h want %h", coeffs, 9'h000); end
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy_n1: got %b want 1", busy); end
    tick();
    // cycle N+2
    compared++;
    if (commit !== 1'b1) begin mismatched++; $display("FAIL basic_commit_n2: got %b want 1", commit); end
    compared++;
    if (coeffs !== 9'h08C) begin mismatched++; $display("FAIL basic_coeffs_n2: got %h want %h", coeffs, 9'h08C); end
    compared++;
    if (ready !== 1'b1) begin mismatched++; $display("FAIL basic_ready_n2: got %b want 1", ready); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_n2: got %b want 0", busy); end
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("FAIL basic_err: got %b want 0", err); end
    tick();
    compared++;
    if (commit !== 1'b0) begin mismatched++; $display("FAIL basic_commit_pulse: got %b want 0", commit); end
    $display("frame 4,1,2 committed coeffs=%h", coeffs);
  endtask

  task automatic test_hold();
    logic       exp_ready;
    logic       exp_commit;
    logic [8:0] exp_coeffs;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send_frame(3'd4, 3'd1, 3'd2, 3'd7);
    // k = 1 is cycle N+1; hold high for the first three COMMIT cycles.
    for (int k = 1; k <= 5; k++) begin
      hold       = (k <= 3);
      exp_ready  = (k == 5);
      exp_commit = (k == 5);
      exp_coeffs = (k == 5) ? 9'h08C : 9'h000;
      compared++;
      if (ready !== exp_ready) begin mismatched++; $display("FAIL hold_ready[N+%0d]: got %b want %b", k, ready, exp_ready); end
      compared++;
      if (commit !== exp_commit) begin mismatched++; $display("FAIL hold_commit[N+%0d]: got %b want %b", k, commit, exp_commit); end
      compared++;
      if (coeffs !== exp_coeffs) begin mismatched++; $display("FAIL hold_coeffs[N+%0d]: got %h want %h", k, coeffs, exp_coeffs); end
      tick();
    end
    hold = 1'b0;
    $display("held frame committed coeffs=%h", coeffs);
  endtask

  task automatic test_restart();
    int err_count;
    err_count = 0;
    beat(1'b1, 3'd4);
    if (err === 1'b1) err_count++;
    beat(1'b0, 3'd1);
    if (err === 1'b1) err_count++;
    beat(1'b1, 3'd3);
    compared++;
    if (err !== 1'b1) begin mismatched++; $display("FAIL restart_err_pulse: got %b want 1", err); end
    if (err === 1'b1) err_count++;
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL restart_busy: got %b want 1", busy); end
    beat(1'b0, 3'd5);
    if (err === 1'b1) err_count++;
    beat(1'b0, 3'd6);
    if (err === 1'b1) err_count++;
`ifdef FIR_COEFF_CHECKSUM_EN
    beat(1'b0, 3'd0);
    if (err === 1'b1) err_count++;
`endif
    tick();
    if (err === 1'b1) err_count++;
    compared++;
    if (commit !== 1'b1) begin mismatched++; $display("FAIL restart_commit: got %b want 1", commit); end
    compared++;
    if (coeffs !== 9'h1AB) begin mismatched++; $display("FAIL restart_coeffs: got %h want %h", coeffs, 9'h1AB); end
    compared++;
    if (err_count !== 1) begin mismatched++; $display("FAIL restart_err_count: got %0d want 1", err_count); end
    $display("restarted frame committed coeffs=%h", coeffs);
  endtask

  task automatic test_idle_discard();
    tick();
    beat(1'b0, 3'd5);
    compared++;
    if (err !== 1'b1) begin mismatched++; $display("FAIL idle_err: got %b want 1", err); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy: got %b want 0", busy); end
    compared++;
    if (coeffs !== 9'h1AB) begin mismatched++; $display("FAIL idle_coeffs: got %h want %h", coeffs, 9'h1AB); end
    tick();
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("FAIL idle_err_pulse: got %b want 0", err); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy_after: got %b want 0", busy); end
    $display("idle stray beat discarded");
  endtask

  task automatic test_reset_mid_frame();
    send_frame(3'd4, 3'd1, 3'd2, 3'd7);
    tick();
    compared++;
    if (coeffs !== 9'h08C) begin mismatched++; $display("FAIL midrst_pre_coeffs: got %h want %h", coeffs, 9'h08C); end
    beat(1'b1, 3'd7);
    beat(1'b0, 3'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if (coeffs !== 9'h000) begin mismatched++; $display("FAIL midrst_coeffs: got %h want %h", coeffs, 9'h000); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b want 0", busy); end
    compared++;
    if (ready !== 1'b1) begin mismatched++; $display("FAIL midrst_ready: got %b want 1", ready); end
    send_frame(3'd1, 3'd2, 3'd3, 3'd0);
    tick();
    compared++;
    if (commit !== 1'b1) begin mismatched++; $display("FAIL midrst_commit: got %b want 1", commit); end
    compared++;
    if (coeffs !== 9'h0D1) begin mismatched++; $display("FAIL midrst_new_coeffs: got %h want %h", coeffs, 9'h0D1); end
    $display("post-reset frame committed coeffs=%h", coeffs);
  endtask

  task automatic test_back_to_back();
    tick();
    send_frame(3'd3, 3'd5, 3'd6, 3'd0);
    compared++;
    if (ready !== 1'b0) begin mismatched++; $display("FAIL b2b_ready_gap: got %b want 0", ready); end
    tick();
    compared++;
    if (coeffs !== 9'h1AB) begin mismatched++; $display("FAIL b2b_first: got %h want %h", coeffs, 9'h1AB); end
    compared++;
    if (ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_resume: got %b want 1", ready); end
    send_frame(3'd4, 3'd1, 3'd2, 3'd7);
    tick();
    compared++;
    if (commit !== 1'b1) begin mismatched++; $display("FAIL b2b_commit2: got %b want 1", commit); end
    compared++;
    if (coeffs !== 9'h08C) begin mismatched++; $display("FAIL b2b_second: got %h want %h", coeffs, 9'h08C); end
    $display("back-to-back frames committed coeffs=%h", coeffs);
  endtask

`ifdef FIR_COEFF_CHECKSUM_EN
  task automatic test_checksum_bad();
    int commits;
    commits = 0;
    tick();
    beat(1'b1, 3'd1);
    beat(1'b0, 3'd2);
    beat(1'b0, 3'd3);
    beat(1'b0, 3'd6);
    compared++;
    if (err !== 1'b1) begin mismatched++; $display("FAIL csum_err: got %b want 1", err); end
    compared++;
    if (ready !== 1'b1) begin mismatched++; $display("FAIL csum_ready: got %b want 1", ready); end
    for (int k = 0; k < 4; k++) begin
      if (commit === 1'b1) commits++;
      tick();
    end
    compared++;
    if (commits !== 0) begin mismatched++; $display("FAIL csum_commits: got %0d want 0", commits); end
    compared++;
    if (coeffs !== 9'h08C) begin mismatched++; $display("FAIL csum_coeffs: got %h want %h", coeffs, 9'h08C); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL csum_busy: got %b want 0", busy); end
    $display("bad checksum frame dropped");
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    rst   = 1'b1;
    valid = 1'b0;
    start = 1'b0;
    data  = 3'd0;
    hold  = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_restart();
    test_idle_discard();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef FIR_COEFF_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Streams a new coefficient set into the FIR tap chain over a valid/ready beat interface, staging it in a shadow bank and committing it atomically to the active bank that drives the taps' coefficient inputs. It is the write side of the coefficient path the filter reads every cycle. It sits between the host/config source and the filter's coefficient inputs. It guarantees the filter never sees a partially loaded set.

## Interface
- NUM_TAPS, 3, number of coefficients per set (≥2)
- COEFF_W, 3, coefficient width in bits, unsigned
- IDX_W, $clog2(NUM_TAPS+1), beat index counter width
- i_CLK  in  1  clock, all logic on rising edge
- i_RST  in  1  synchronous, active-high reset
- i_valid  in  1  beat present on i_data
- i_start  in  1  qualifies the beat as first of a frame (coefficient index 0)
- i_data  in  COEFF_W  coefficient (or checksum) beat
- o_ready  out  1  loader accepts a beat this cycle
- i_hold  in  1  filter blocks the bank swap while high
- o_coeffs  out  NUM_TAPS*COEFF_W  active set; coefficient k at bits [k*COEFF_W +: COEFF_W]
- o_commit  out  1  one-cycle pulse, first cycle new o_coeffs is visible
- o_busy  out  1  state ≠ IDLE
- o_err  out  1  one-cycle pulse on protocol/checksum error

## Operation
- Accept = i_valid && o_ready. o_ready = (state ≠ COMMIT), combinational from state only.
- States: IDLE, LOAD, COMMIT.
- IDLE: an accepted beat with i_start=1 writes shadow[0], idx←1, →LOAD. An accepted beat with i_start=0 is discarded and pulses o_err.
- LOAD: an accepted beat with i_start=0 writes shadow[idx], idx+1. The beat that completes the frame (idx = FRAME_LEN-1) →COMMIT.
- LOAD, accepted beat with i_start=1: pulses o_err and restarts the frame. The beat is written to shadow[0], idx←1, state stays LOAD.
- COMMIT: while i_hold=1, wait. When i_hold=0, active←shadow at the cycle end, o_commit pulses the next cycle, →IDLE.
- Idle cycles (i_valid=0) inside a frame are allowed, with no timeout.
- The active bank changes only on commit. o_coeffs is a direct register output.
- Reset values: active bank all zero, shadow all zero, o_coeffs=0, o_commit=0, o_err=0, o_busy=0, state IDLE.
- Reset mid-frame or mid-COMMIT discards the shadow and zeros the active bank.

## Timing
- The last frame beat is accepted in cycle N. State is COMMIT in N+1, so o_ready=0 in N+1.
- With i_hold=0 in N+1: o_coeffs shows the new set and o_commit=1 in N+2, o_ready=1 again in N+2. This is 2-cycle commit latency.
- Each i_hold cycle adds one cycle of latency.
- o_err is registered, high in the cycle after the offending accept.
- o_busy is registered from state, high from the cycle after the first accepted beat through the COMMIT cycle.
- Throughput: one beat per cycle in IDLE/LOAD. Back-to-back frames lose exactly the COMMIT cycle(s).

## Configuration
- FIR_COEFF_CHECKSUM_EN defined: FRAME_LEN = NUM_TAPS+1. The final beat is the XOR of all coefficients.
  - On mismatch: o_err pulses, no commit, →IDLE. The active bank is unchanged.
  - On match: →COMMIT as above.
- Undefined: FRAME_LEN = NUM_TAPS. No checksum logic.

## Structure
- Package fir_pkg:
  - state enum (IDLE, LOAD, COMMIT)
  - default NUM_TAPS and COEFF_W constants, shared with the filter
  - function computing the XOR checksum over a packed coefficient vector
- One sub-module, fir_coeff_bank:
  - shadow and active register arrays
  - indexed shadow write
  - swap-on-commit
  - packed o_coeffs output
- The FSM, index counter and checksum compare stay in the top.

## Test plan
- Reset, then load 4,1,2 (start on 4) with i_hold=0 → o_commit pulses 2 cycles after the last beat, o_coeffs = 9'h08C. With CHECKSUM_EN, append 7.
- Same frame with i_hold high for 3 cycles in COMMIT → o_ready=0 for 4 cycles, commit 5 cycles after the last beat. o_coeffs stays 0 until then.
- Load 4,1, then start-beat 3 mid-frame, then 5,6 → o_err pulse once. Final o_coeffs = {6,5,3} = 9'h1AB.
- In IDLE, beat 5 with i_start=0 → o_err pulse, o_busy stays 0, o_coeffs unchanged.
- After committing 9'h08C, start a frame 7,7 and assert i_RST → o_coeffs=0, state IDLE. A new frame 1,2,3 commits 9'h0D1.
- CHECKSUM_EN: frame 4,1,2 with checksum 6 → o_err pulse, no o_commit, o_coeffs unchanged.
